fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 79 +++++++
 tb/tb_fifo_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing defaults for the FIFO controller and its pointer counters.
// Optional level flags are enabled by defining FIFO_CTRL_LEVEL_FLAGS_EN.
package fifo_pkg;
  localparam int ADDR_W_DEF   = 4;
  localparam int PTR_W_DEF    = ADDR_W_DEF + 1;
  localparam int AF_LEVEL_DEF = 12;
  localparam int AE_LEVEL_DEF = 4;
endpackage

// File: rtl/fifo_ptr.sv
// Binary wrap counter with enable; the MSB is the lap bit.
// Used for both the write and read pointers of fifo_ctrl.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = PTR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, sticky errors.
// Define FIFO_CTRL_LEVEL_FLAGS_EN to enable almost_full/almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr_err,
  output logic            fifo_we,
  output logic [ADDR_W:0] wptr,
  output logic [ADDR_W:0] rptr,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic [ADDR_W:0] fifo_count,
  output logic            overflow,
  output logic            underflow,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam int PW = ADDR_W + 1;

  logic rd_en;
  logic ovf_set;
  logic udf_set;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign fifo_count = wptr - rptr;

  // Gate with rst so no write strobe escapes while held in reset.
  assign fifo_we = wr & ~fifo_full & ~rst;
  assign rd_en   = rd & ~fifo_empty & ~rst;
  assign ovf_set = wr & fifo_full;
  assign udf_set = rd & fifo_empty;

  fifo_ptr #(.W(PW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .en  (fifo_we),
    .ptr (wptr)
  );

  fifo_ptr #(.W(PW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_en),
    .ptr (rptr)
  );

  // A new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

`ifdef FIFO_CTRL_LEVEL_FLAGS_EN
  assign almost_full  = int'(fifo_count) >= AF_LEVEL;
  assign almost_empty = int'(fifo_count) <= AE_LEVEL;
`else
  logic [31:0] unused_levels;
  assign unused_levels = AF_LEVEL ^ AE_LEVEL;
  assign almost_full   = 1'b0;
  assign almost_empty  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed plus random bench for fifo_ctrl against a queue-based model.
// Level-flag checks follow FIFO_CTRL_LEVEL_FLAGS_EN.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic       fifo_we;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       underflow;
  logic       almost_full;
  logic       almost_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of write addresses, lifetime write/read totals, error flags.
  int q[$];
  int wtot = 0;
  int rtot = 0;
  bit m_ovf = 0;
  bit m_udf = 0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .fifo_we      (fifo_we),
    .wptr         (wptr),
    .rptr         (rptr),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wtot = 0;
    rtot = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic check_all(input string tag);
    int c;
    c = q.size();
    chk({tag, ".wptr"}, 32'(wptr), 32'(wtot % 32));
    chk({tag, ".rptr"}, 32'(rptr), 32'(rtot % 32));
    chk({tag, ".count"}, 32'(fifo_count), 32'(c));
    chk({tag, ".full"}, 32'(fifo_full), 32'(c == 16));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(c == 0));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_CTRL_LEVEL_FLAGS_EN
    chk({tag, ".af"}, 32'(almost_full), 32'(c >= 12));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(c <= 4));
`else
    chk({tag, ".af"}, 32'(almost_full), 32'd0);
    chk({tag, ".ae"}, 32'(almost_empty), 32'd0);
`endif
  endtask

  task automatic cycle(input string tag, input bit w, input bit r,
                       input bit c);
    bit acc_w;
    bit acc_r;
    @(negedge clk);
    wr = w;
    rd = r;
    clr_err = c;
    #1;
    acc_w = w && (q.size() < 16);
    acc_r = r && (q.size() > 0);
    chk({tag, ".we"}, 32'(fifo_we), 32'(acc_w));
    if (acc_r)
      chk({tag, ".raddr"}, 32'(rptr[3:0]), 32'(q[0]));
    @(posedge clk);
    #1;
    if (acc_r) begin
      void'(q.pop_front());
      rtot++;
    end
    if (acc_w) begin
      q.push_back(wtot % 16);
      wtot++;
    end
    m_ovf = (w && !acc_w) || (m_ovf && !c);
    m_udf = (r && !acc_r) || (m_udf && !c);
    check_all(tag);
    wr = 0;
    rd = 0;
    clr_err = 0;
  endtask

  initial begin
    bit w;
    bit r;
    // Reset state
    wr = 1'b1;
    #1;
    chk("rst.we", 32'(fifo_we), 32'd0);
    model_reset();
    check_all("rst");
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fill to full
    for (int i = 0; i < 16; i++) cycle("fill", 1, 0, 0);
    chk("full.wptr", 32'(wptr), 32'h10);
    chk("full.flag", 32'(fifo_full), 32'd1);

    // Overflow while full, sticky until clr_err
    cycle("ovf", 1, 0, 0);
    cycle("ovf_hold", 0, 0, 0);
    cycle("ovf_hold2", 0, 0, 0);
    cycle("ovf_clr", 0, 0, 1);

    // wr and rd together when full
    cycle("full_wr_rd", 1, 1, 0);
    chk("full_wr_rd.cnt15", 32'(fifo_count), 32'd15);

    // clr_err with a fresh error in the same cycle keeps the flag
    cycle("refill", 1, 0, 0);
    cycle("ovf_prio", 1, 0, 1);
    cycle("ovf_clr2", 0, 0, 1);

    // Drain to empty
    for (int i = 0; i < 16; i++) cycle("drain", 0, 1, 0);

    // wr and rd together when empty
    cycle("empty_wr_rd", 1, 1, 0);
    chk("empty_wr_rd.cnt1", 32'(fifo_count), 32'd1);
    cycle("udf_clr", 0, 1, 1);

    // Legal interleaved traffic: 40 items, pointers wrap past 31
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 2) != 0) && (q.size() < 16);
      r = ($urandom_range(0, 1) != 0) && (q.size() > 0);
      cycle("legal", w, r, 0);
    end
    while (q.size() > 0) cycle("legal_drain", 0, 1, 0);
    chk("legal.no_ovf", 32'(overflow), 32'd0);
    chk("legal.no_udf", 32'(underflow), 32'd0);

    // Level-flag thresholds
    for (int i = 0; i < 12; i++) cycle("lvl_fill", 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle("lvl_drain", 0, 1, 0);

    // Unconstrained random traffic including errors and clears
    for (int i = 0; i < 150; i++)
      cycle("rand", 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0);

    // Asynchronous reset with nine entries held
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 9; i++) cycle("pre_ar", 1, 0, 0);
    chk("pre_ar.cnt9", 32'(fifo_count), 32'd9);
    @(negedge clk);
    wr = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar.we", 32'(fifo_we), 32'd0);
    chk("ar.wptr", 32'(wptr), 32'd0);
    chk("ar.rptr", 32'(rptr), 32'd0);
    chk("ar.count", 32'(fifo_count), 32'd0);
    chk("ar.empty", 32'(fifo_empty), 32'd1);
    chk("ar.full", 32'(fifo_full), 32'd0);
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_ar.wptr0", 32'(wptr), 32'd0);
    cycle("post_ar", 1, 0, 0);
    chk("post_ar.wptr1", 32'(wptr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
